// File: rtl/uart_pkg.sv
// Shared constants, state encodings and bit-timing helpers for the framed UART.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int calc_div(input int clock_freq, input int baud_rate);
    return clock_freq / (baud_rate * 16);
  endfunction

  function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
    return 16 * calc_div(clock_freq, baud_rate);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head and
// simultaneous push/pop (a push into a full FIFO succeeds only alongside a pop).
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    valid_d  = (count_d != '0);
    // The new head is the word being written when it lands in the head slot.
    dout_d   = (push_ok && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/uart_frame_top.sv
// Full-duplex UART with compile-time frame format: handshaked TX, 16x oversampled
// RX feeding a FIFO of {frame_err, parity_err, data} words with overrun reporting.
module uart_frame_top
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ    = 1536000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);

  localparam int DIV          = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int STOP_LEN     = STOP_BITS * CLKS_PER_BIT;
  localparam int TXCW         = $clog2(STOP_LEN);
  localparam int DVW          = $clog2(DIV);

  localparam logic [TXCW-1:0] BIT_LAST     = TXCW'(CLKS_PER_BIT - 1);
  localparam logic [TXCW-1:0] STOP_LAST    = TXCW'(STOP_LEN - 1);
  localparam logic [TXCW-1:0] STOP_PRE     = TXCW'(STOP_LEN - 2);
  localparam logic [3:0]      BIT_IDX_LAST = 4'(DATA_BITS - 1);
  localparam logic [DVW-1:0]  DIV_LAST     = DVW'(DIV - 1);
  localparam logic            STOP_IDX_LAST = 1'(STOP_BITS - 1);

  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_frame_top: DATA_BITS must be 5..9");
  end
  if ((PARITY < PAR_NONE) || (PARITY > PAR_ODD)) begin : g_bad_parity
    $error("uart_frame_top: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_frame_top: STOP_BITS must be 1 or 2");
  end
  if ((DIV < 2) || ((CLOCK_FREQ % (BAUD_RATE * 16)) != 0)) begin : g_bad_div
    $error("uart_frame_top: CLOCK_FREQ/(BAUD_RATE*16) must be an integer >= 2");
  end

  // ---------------- transmitter ----------------
  tx_state_e             tx_state_q;
  logic [TXCW-1:0]       tx_cnt_q;
  logic [3:0]            tx_bit_q;
  logic [DATA_BITS-1:0]  tx_shift_q;
  logic                  tx_par_q, tx_serial_q, tx_ready_q, tx_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: if (tx_valid) begin
          tx_shift_q  <= tx_data;
          tx_par_q    <= (PARITY == PAR_ODD) ^ (^tx_data);
          tx_serial_q <= 1'b0;
          tx_ready_q  <= 1'b0;
          tx_cnt_q    <= '0;
          tx_state_q  <= TX_START;
        end
        TX_START: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q    <= '0;
          tx_bit_q    <= '0;
          tx_serial_q <= tx_shift_q[0];
          tx_shift_q  <= tx_shift_q >> 1;
          tx_state_q  <= TX_DATA;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_DATA: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == BIT_IDX_LAST) begin
            if (PARITY != PAR_NONE) begin
              tx_serial_q <= tx_par_q;
              tx_state_q  <= TX_PARITY;
            end else begin
              tx_serial_q <= 1'b1;
              tx_state_q  <= TX_STOP;
            end
          end else begin
            tx_bit_q    <= tx_bit_q + 1'b1;
            tx_serial_q <= tx_shift_q[0];
            tx_shift_q  <= tx_shift_q >> 1;
          end
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_PARITY: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q    <= '0;
          tx_serial_q <= 1'b1;
          tx_state_q  <= TX_STOP;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        TX_STOP: begin
          // Registered pulse, so it is armed one cycle ahead of the last stop cycle.
          tx_done_q <= (tx_cnt_q == STOP_PRE);
          if (tx_cnt_q == STOP_LAST) begin
            tx_ready_q <= 1'b1;
            tx_state_q <= TX_IDLE;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_ready  = tx_ready_q;
  assign tx_done   = tx_done_q;

  // ---------------- receiver ----------------
  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e             rx_state_q;
  logic [DVW-1:0]        rx_div_q;
  logic [3:0]            rx_os_q, rx_bit_q;
  logic                  rx_stop_q, rx_par_q, rx_ferr_q;
  logic [DATA_BITS-1:0]  rx_shift_q;
  logic                  rx_push_q, rx_overrun_q;
  logic [DATA_BITS+1:0]  rx_word_q, rx_head;
  logic                  rx_sample, rx_calc_par, rx_ferr_now, rx_pop, fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    rx_sample   = (rx_state_q != RX_IDLE) && (rx_div_q == DIV_LAST) && (rx_os_q == 4'd7);
    rx_calc_par = (PARITY == PAR_ODD) ^ (^rx_shift_q);
    rx_ferr_now = rx_ferr_q | ~rx_sync_q;
    rx_pop      = rx_valid & rx_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      rx_div_q     <= '0;
      rx_os_q      <= '0;
      rx_bit_q     <= '0;
      rx_stop_q    <= 1'b0;
      rx_par_q     <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_shift_q   <= '0;
      rx_push_q    <= 1'b0;
      rx_word_q    <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_push_q    <= 1'b0;
      rx_overrun_q <= rx_push_q & fifo_full & ~rx_pop;
      if (rx_state_q != RX_IDLE) begin
        if (rx_div_q == DIV_LAST) begin
          rx_div_q <= '0;
          rx_os_q  <= rx_os_q + 1'b1;
        end else rx_div_q <= rx_div_q + 1'b1;
      end
      case (rx_state_q)
        RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_div_q   <= '0;
          rx_os_q    <= '0;
          rx_state_q <= RX_START;
        end
        RX_START: if (rx_sample) begin
          rx_bit_q   <= '0;
          rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_sample) begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_stop_q  <= 1'b0;
          rx_ferr_q  <= 1'b0;
          if (rx_bit_q == BIT_IDX_LAST)
            rx_state_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          else
            rx_bit_q <= rx_bit_q + 1'b1;
        end
        RX_PARITY: if (rx_sample) begin
          rx_par_q   <= rx_sync_q;
          rx_state_q <= RX_STOP;
        end
        RX_STOP: if (rx_sample) begin
          if (rx_stop_q == STOP_IDX_LAST) begin
            rx_push_q  <= 1'b1;
            rx_word_q  <= {rx_ferr_now, (PARITY != PAR_NONE) && (rx_par_q != rx_calc_par),
                           rx_shift_q};
            rx_state_q <= RX_IDLE;
          end else begin
            rx_stop_q <= 1'b1;
            rx_ferr_q <= rx_ferr_now;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_push_q),
    .din  (rx_word_q),
    .pop  (rx_ready),
    .dout (rx_head),
    .valid(rx_valid),
    .full (fifo_full)
  );

  assign {rx_frame_err, rx_parity_err, rx_data} = rx_head;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_frame_top.sv
// Directed bench: 8N1, 8E2 (loopback + injected errors) and 8O1 instances of uart_frame_top.
module tb_uart_frame_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] txd [3];
  logic       txv [3];
  logic       rxr [3];
  logic       drv [3];
  logic       loop_e;

  logic       tx_ser_n, tx_rdy_n, tx_dn_n, rx_vld_n, rx_pe_n, rx_fe_n, rx_ovr_n;
  logic       tx_ser_e, tx_rdy_e, tx_dn_e, rx_vld_e, rx_pe_e, rx_fe_e, rx_ovr_e;
  logic       tx_ser_o, tx_rdy_o, tx_dn_o, rx_vld_o, rx_pe_o, rx_fe_o, rx_ovr_o;
  logic [7:0] rx_dat_n, rx_dat_e, rx_dat_o;
  logic       rx_in_e, rx_in_o;

  assign rx_in_e = loop_e ? tx_ser_e : drv[1];
  assign rx_in_o = tx_ser_o;

  uart_frame_top dut_n (
    .clk(clk), .rst(rst), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_rdy_n),
    .tx_serial(tx_ser_n), .tx_done(tx_dn_n), .rx_serial(drv[0]), .rx_data(rx_dat_n),
    .rx_parity_err(rx_pe_n), .rx_frame_err(rx_fe_n), .rx_valid(rx_vld_n),
    .rx_ready(rxr[0]), .rx_overrun(rx_ovr_n));

  uart_frame_top #(.PARITY(1), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst(rst), .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_rdy_e),
    .tx_serial(tx_ser_e), .tx_done(tx_dn_e), .rx_serial(rx_in_e), .rx_data(rx_dat_e),
    .rx_parity_err(rx_pe_e), .rx_frame_err(rx_fe_e), .rx_valid(rx_vld_e),
    .rx_ready(rxr[1]), .rx_overrun(rx_ovr_e));

  uart_frame_top #(.PARITY(2)) dut_o (
    .clk(clk), .rst(rst), .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(tx_rdy_o),
    .tx_serial(tx_ser_o), .tx_done(tx_dn_o), .rx_serial(rx_in_o), .rx_data(rx_dat_o),
    .rx_parity_err(rx_pe_o), .rx_frame_err(rx_fe_o), .rx_valid(rx_vld_o),
    .rx_ready(rxr[2]), .rx_overrun(rx_ovr_o));

  int sel = 0;
  logic       mon_ser, mon_rdy, mon_dn, mon_vld, mon_pe, mon_fe;
  logic [7:0] mon_dat;

  always_comb begin
    mon_ser = tx_ser_n; mon_rdy = tx_rdy_n; mon_dn = tx_dn_n;
    mon_vld = rx_vld_n; mon_pe = rx_pe_n; mon_fe = rx_fe_n; mon_dat = rx_dat_n;
    if (sel == 1) begin
      mon_ser = tx_ser_e; mon_rdy = tx_rdy_e; mon_dn = tx_dn_e;
      mon_vld = rx_vld_e; mon_pe = rx_pe_e; mon_fe = rx_fe_e; mon_dat = rx_dat_e;
    end else if (sel == 2) begin
      mon_ser = tx_ser_o; mon_rdy = tx_rdy_o; mon_dn = tx_dn_o;
      mon_vld = rx_vld_o; mon_pe = rx_pe_o; mon_fe = rx_fe_o; mon_dat = rx_dat_o;
    end
  end

  int ovr_cnt = 0;
  always @(posedge clk) if (rx_ovr_n) ovr_cnt <= ovr_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b111111, 1'b1, d, 1'b0};
  endfunction

  // Send one byte on instance s and check every bit boundary against a frame model.
  task automatic tx_frame(input int s, input logic [7:0] d, input int par, input int nstop);
    logic [15:0] bits;
    int nb, len;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    nb = 9;
    if (par != 0) begin
      bits[9] = (par == 2) ^ (^d);
      nb = 10;
    end
    nb  = nb + nstop;
    len = nb * 160;
    sel = s;
    @(negedge clk);
    check_eq("tx_ready_idle", 32'(mon_rdy), 1);
    txd[s] = d;
    txv[s] = 1'b1;
    @(posedge clk);
    #1 txv[s] = 1'b0;
    for (int k = 1; k <= len; k++) begin
      if (((k - 1) % 160 == 0) || (k % 160 == 0))
        check_eq($sformatf("tx%0d_bit%0d_clk%0d", s, (k - 1) / 160, k), 32'(mon_ser),
                 32'(bits[(k - 1) / 160]));
      if ((k == 1) || (k == len)) check_eq("tx_ready_busy", 32'(mon_rdy), 0);
      if (k >= len - 1) check_eq($sformatf("tx_done_clk%0d", k), 32'(mon_dn), 32'(k == len));
      @(posedge clk);
      #1;
    end
    check_eq("tx_done_after", 32'(mon_dn), 0);
    check_eq("tx_ready_after", 32'(mon_rdy), 1);
  endtask

  task automatic rx_drive(input int s, input logic [15:0] bits, input int nb);
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      drv[s] = bits[i];
      repeat (160) @(negedge clk);
    end
    drv[s] = 1'b1;
  endtask

  task automatic pop_rx(input int s);
    @(negedge clk);
    rxr[s] = 1'b1;
    @(negedge clk);
    rxr[s] = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check_eq({tag, "_valid"}, 32'(mon_vld), 1);
    check_eq({tag, "_data"}, 32'(mon_dat), 32'(d));
    check_eq({tag, "_perr"}, 32'(mon_pe), 32'(pe));
    check_eq({tag, "_ferr"}, 32'(mon_fe), 32'(fe));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ovr0;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      txd[i] = '0; txv[i] = 1'b0; rxr[i] = 1'b0; drv[i] = 1'b1;
    end
    loop_e = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_serial", 32'(tx_ser_n), 1);
    check_eq("rst_tx_ready", 32'(tx_rdy_n), 1);
    check_eq("rst_tx_done", 32'(tx_dn_n), 0);
    check_eq("rst_rx_valid", 32'(rx_vld_n), 0);
    check_eq("rst_rx_data", 32'(rx_dat_n), 0);
    check_eq("rst_rx_flags", {30'd0, rx_pe_n, rx_fe_n}, 0);
    check_eq("rst_rx_overrun", 32'(rx_ovr_n), 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);

    tx_frame(0, 8'h55, 0, 1);

    tx_frame(1, 8'hA5, 1, 2);
    check_head("loop_even", 8'hA5, 1'b0, 1'b0);
    pop_rx(1);
    check_eq("loop_even_popped", 32'(mon_vld), 0);

    tx_frame(2, 8'hA5, 2, 1);
    check_head("loop_odd", 8'hA5, 1'b0, 1'b0);
    pop_rx(2);
    check_eq("loop_odd_popped", 32'(mon_vld), 0);

    loop_e = 1'b0;
    sel = 1;
    rx_drive(1, {4'b1111, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 12);
    check_head("rx_parity_err", 8'h07, 1'b1, 1'b0);
    pop_rx(1);
    rx_drive(1, {4'b1111, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 12);
    check_head("rx_frame_err", 8'h07, 1'b0, 1'b1);
    pop_rx(1);
    check_eq("rx_err_popped", 32'(mon_vld), 0);

    sel = 0;
    @(negedge clk) drv[0] = 1'b0;
    repeat (40) @(negedge clk);
    drv[0] = 1'b1;
    repeat (400) @(negedge clk);
    check_eq("glitch_no_push", 32'(mon_vld), 0);

    ovr0 = ovr_cnt;
    for (int i = 0; i < 5; i++) begin
      d = 8'h11 * 8'(i + 1);
      rx_drive(0, f8n1(d), 10);
      if (i == 0) check_head("fifo_first", 8'h11, 1'b0, 1'b0);
      if (i == 3) check_eq("no_overrun_at_4", 32'(ovr_cnt - ovr0), 0);
    end
    check_eq("overrun_pulses", 32'(ovr_cnt - ovr0), 1);
    for (int i = 0; i < 4; i++) begin
      d = 8'h11 * 8'(i + 1);
      check_head($sformatf("drain%0d", i), d, 1'b0, 1'b0);
      pop_rx(0);
    end
    check_eq("drain_empty", 32'(mon_vld), 0);

    sel = 0;
    @(negedge clk);
    txd[0] = 8'h3C;
    txv[0] = 1'b1;
    @(posedge clk);
    #1 txv[0] = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check_eq("pre_rst_data_bit1", 32'(mon_ser), 0);
    rst = 1'b1;
    #1;
    check_eq("midrst_tx_serial", 32'(mon_ser), 1);
    check_eq("midrst_tx_ready", 32'(mon_rdy), 1);
    check_eq("midrst_tx_done", 32'(mon_dn), 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    tx_frame(0, 8'h96, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_top.md
Name: uart_frame_top

Overview:
Second-generation UART top: full-duplex TX/RX with compile-time frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits).
- TX uses a valid/ready handshake.
- RX has a buffered receive FIFO with per-byte error flags and overrun reporting.
- Bit timing is derived internally from CLOCK_FREQ/BAUD_RATE with 16x oversampling.
- Sits between the host-side bus adapter and the pads, replacing the single-byte uart_top.

Parameters:
- CLOCK_FREQ, 1536000: system clock in Hz.
- BAUD_RATE, 9600: line rate. DIV = CLOCK_FREQ/(BAUD_RATE*16) must be an integer ≥2 (default 10); CLKS_PER_BIT = 16*DIV.
- DATA_BITS, 8: payload bits per frame, legal 5..9.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- RX_FIFO_DEPTH, 4: receive FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- tx_data  in  DATA_BITS  byte to send; sampled on handshake
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX idle, can accept
- tx_serial  out  1  serial line, idle high
- tx_done  out  1  one-cycle pulse at end of last stop bit
- rx_serial  in  1  serial line, asynchronous
- rx_data  out  DATA_BITS  FIFO head payload
- rx_parity_err  out  1  FIFO head parity error flag
- rx_frame_err  out  1  FIFO head framing error flag
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer pops head when rx_valid&rx_ready
- rx_overrun  out  1  one-cycle pulse: completed frame dropped, FIFO full

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: tx_serial=1, tx_ready=1, tx_done=0, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0. FIFO is emptied. Both FSMs return to IDLE.
- Reset mid-frame: the TX frame is abandoned and the line returns high immediately. A partial RX frame is discarded.
- TX FSM states: IDLE→START→DATA→PARITY (skipped if PARITY=0)→STOP→IDLE.
  - Handshake when tx_valid&tx_ready in IDLE: data is latched, and tx_ready falls the next cycle.
  - tx_serial=0 from the cycle after acceptance.
  - Each bit lasts exactly CLKS_PER_BIT clocks, counted by a dedicated TX counter (no shared free-running tick). Data is sent LSB first.
  - Parity bit: even = XOR of data bits; odd = its inverse.
  - STOP holds 1 for STOP_BITS*CLKS_PER_BIT clocks.
  - tx_done pulses in the final STOP cycle; tx_ready=1 the next cycle.
  - Back-to-back: tx_valid held high starts the next start bit with no idle gap beyond that one cycle.
  - tx_valid while busy is ignored, not queued.
- RX input: rx_serial passes a 2-flop synchronizer (2-cycle latency).
- RX FSM states: IDLE→START→DATA→PARITY (optional)→STOP→IDLE.
  - IDLE: a falling edge on the synchronized line restarts the RX 16x divider (period DIV clocks).
  - START: at oversample count 8 the line is re-sampled. If 1, it is a glitch: return to IDLE, nothing pushed.
  - Each subsequent bit is sampled once at its count 8 (mid-bit).
  - Parity error: received parity ≠ computed parity.
  - Framing error: any stop bit sampled 0. With STOP_BITS=2 both are checked.
  - The frame completes at the mid-point of the last stop bit. The FSM returns to IDLE there and can detect a new start edge the following cycle.
- RX FIFO: each entry is {frame_err, parity_err, data}.
  - Push on frame completion. Frames with errors are still pushed.
  - Push while full: frame dropped, rx_overrun pulses 1 cycle, FIFO contents unchanged.
  - Pop when rx_valid&rx_ready.
  - Simultaneous push and pop when full: both succeed, no overrun.
  - Outputs are the registered head (first-word-fall-through). rx_valid rises 1 cycle after push into an empty FIFO.
  - Pointers wrap modulo RX_FIFO_DEPTH. Occupancy counter width is log2(DEPTH)+1.
- Out-of-range parameters (DATA_BITS, PARITY, STOP_BITS, DIV<2) trigger an elaboration-time error.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - TX and RX state encodings;
  - the localparam function computing DIV and CLKS_PER_BIT.
- Sub-module uart_sync_fifo: parameterised width/depth, FWFT, full/empty, simultaneous push/pop. Instanced once for RX with width DATA_BITS+2.
- TX and RX FSMs live in the top.

Test Plan:
- 8N1 defaults, send tx_data=0x55 → tx_serial low 160 clocks, bits 1,0,1,0,1,0,1,0 each 160 clocks, stop high 160 clocks. tx_done pulses at clock 1600 after acceptance. tx_ready is low throughout.
- PARITY=1, send 0xA5 → parity bit 0. Same with PARITY=2 → parity bit 1. Loop tx_serial to rx_serial → rx_data=0xA5, both error flags 0.
- Drive rx_serial with 0x07 and a wrong even-parity bit (0) → rx_parity_err=1, data 0x07. A stop bit forced to 0 → rx_frame_err=1.
- 40-clock low glitch on idle rx_serial → no push, rx_valid stays 0.
- rx_ready=0, send 5 frames into DEPTH=4 → first 4 held in order, rx_overrun pulses once at 5th completion. Draining returns frames 1–4.
- Assert rst mid-DATA bit of a TX frame → tx_serial=1 and tx_ready=1 immediately. The next transfer after release is bit-exact.
